// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr -- round-robin owner of the single shared-bus master port.
//
// A requester wins a one-hot grant, keeps it through exactly one
// beginTransaction/endTransaction pair, and then drops to lowest priority.
// A granted master that neither begins nor keeps requesting loses the grant.
// Every grant is followed by at least one IDLE cycle (bus turnaround).
//
// Optional build macro: ARB_WATCHDOG_EN
//   defined   - ACTIVE transactions longer than ACTIVE_TIMEOUT cycles are
//               force-ended with a one-cycle endTransactionOut/busErrorOut.
//   undefined - no watchdog; endTransactionOut/busErrorOut are tied 0.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   requestTransaction  per-master request
//   transactionGranted  registered one-hot (or zero) grant
//   grantedId           index of the grant holder, 0 when no grant
//   beginTransactionIn  shared-bus begin (OR of all masters)
//   endTransactionIn    shared-bus end
//   busErrorIn          shared-bus error (does not alter sequencing)
//   arbiterBusy         registered, high in GRANTED or ACTIVE
//   endTransactionOut   watchdog-forced end pulse
//   busErrorOut         watchdog-forced error pulse
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int GRANT_TIMEOUT  = 16,
    parameter int ACTIVE_TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] requestTransaction,
    output logic [NUM_MASTERS-1:0] transactionGranted,
    output logic [2:0]             grantedId,
    input  logic                   beginTransactionIn,
    input  logic                   endTransactionIn,
    input  logic                   busErrorIn,
    output logic                   arbiterBusy,
    output logic                   endTransactionOut,
    output logic                   busErrorOut
);
    typedef enum logic [1:0] {IDLE, GRANTED, ACTIVE} state_t;

    localparam int GT_W = $clog2(GRANT_TIMEOUT + 2);

    state_t                 state;
    logic [2:0]             ptr;
    logic [GT_W-1:0]        grant_cnt;
    logic [2:0]             winner;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic                   found;
    logic [2:0]             next_ptr;
    logic                   holder_req;
    logic                   grant_hit;
    logic                   wd_hit;
    logic                   unused_inputs;

    // A bus error only matters once the end arrives, so the error input has
    // no effect on sequencing; ACTIVE_TIMEOUT is only consumed by the watchdog.
    assign unused_inputs = busErrorIn ^ (ACTIVE_TIMEOUT == 0);

    // Rotating priority scan: first set request at or above ptr, wrapping.
    always_comb begin
        winner     = '0;
        win_onehot = '0;
        found      = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            for (int c = 0; c < NUM_MASTERS; c++) begin
                if (!found && requestTransaction[c] &&
                    c == (int'(ptr) + k) % NUM_MASTERS) begin
                    found         = 1'b1;
                    winner        = 3'(c);
                    win_onehot[c] = 1'b1;
                end
            end
        end
    end

    // Served master becomes lowest priority.
    assign next_ptr   = (int'(grantedId) == NUM_MASTERS - 1) ? 3'd0 : grantedId + 3'd1;
    assign holder_req = |(requestTransaction & transactionGranted);
    assign grant_hit  = (GRANT_TIMEOUT != 0) && (int'(grant_cnt) + 1 == GRANT_TIMEOUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            ptr                <= '0;
            grant_cnt          <= '0;
            transactionGranted <= '0;
            grantedId          <= '0;
            arbiterBusy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state              <= GRANTED;
                        transactionGranted <= win_onehot;
                        grantedId          <= winner;
                        arbiterBusy        <= 1'b1;
                        grant_cnt          <= '0;
                    end
                end
                GRANTED: begin
                    grant_cnt <= grant_cnt + 1'b1;
                    // begin beats a same-cycle request drop or timeout
                    if (beginTransactionIn) begin
                        state <= ACTIVE;
                    end else if (!holder_req || grant_hit) begin
                        state              <= IDLE;
                        transactionGranted <= '0;
                        grantedId          <= '0;
                        arbiterBusy        <= 1'b0;
                        // a withdrawn request keeps its priority; a stalled one loses it
                        if (holder_req)
                            ptr <= next_ptr;
                    end
                end
                ACTIVE: begin
                    if (endTransactionIn || wd_hit) begin
                        state              <= IDLE;
                        transactionGranted <= '0;
                        grantedId          <= '0;
                        arbiterBusy        <= 1'b0;
                        ptr                <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(ACTIVE_TIMEOUT + 2);

    logic [WD_W-1:0] wd_cnt;

    // A real end in the same cycle takes precedence over the forced end.
    assign wd_hit = (state == ACTIVE) && !endTransactionIn &&
                    (int'(wd_cnt) + 1 == ACTIVE_TIMEOUT);

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt            <= '0;
            endTransactionOut <= 1'b0;
            busErrorOut       <= 1'b0;
        end else begin
            endTransactionOut <= wd_hit;
            busErrorOut       <= wd_hit;
            if (state != ACTIVE || wd_hit)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_hit            = 1'b0;
    assign endTransactionOut = 1'b0;
    assign busErrorOut       = 1'b0;
`endif

endmodule
